// File: rtl/neuron_accumulator.sv
// Accumulates signed ALU results per neuron, applies an activation on the last beat
// and queues results in a FWFT FIFO. Define SAT_ACCUM_EN for saturating accumulation plus sat_flag.
module neuron_accumulator #(
    parameter int nBits = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [nBits-1:0] alu_result,
    input  logic             in_last,
    input  logic [1:0]       act_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [nBits-1:0] out_data,
    output logic [AW:0]      fifo_count
`ifdef SAT_ACCUM_EN
    ,
    output logic             sat_flag
`endif
);

    typedef enum logic [1:0] {ACCUM, ACT, PUSH} state_t;

    localparam logic signed [nBits-1:0] ONE      = {{(nBits-1){1'b0}}, 1'b1};
    localparam logic [AW:0]             FULL_CNT = (AW+1)'(DEPTH);

    state_t                  state, state_nxt;
    logic signed [nBits-1:0] alu_s;
    logic signed [nBits-1:0] acc_p0;
    logic signed [nBits-1:0] sum_p0;
    logic                    first_p0;
    logic [1:0]              act_sel_p0;
    logic signed [nBits-1:0] res_p1;
    logic                    accept, push, pop, full;

    logic [nBits-1:0]        mem [DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [AW:0]             count;

`ifdef SAT_ACCUM_EN
    logic                    ovf_p0;

    // Returns {overflow, clamped sum}; overflow only when both operands share a sign the sum lacks.
    function automatic logic [nBits:0] sat_add(input logic signed [nBits-1:0] a,
                                               input logic signed [nBits-1:0] b);
        logic signed [nBits-1:0] s;
        logic                    ovf;
        s   = a + b;
        ovf = (a[nBits-1] == b[nBits-1]) && (s[nBits-1] != a[nBits-1]);
        if (ovf)
            s = a[nBits-1] ? {1'b1, {(nBits-1){1'b0}}} : {1'b0, {(nBits-1){1'b1}}};
        return {ovf, s};
    endfunction
`endif

    function automatic logic signed [nBits-1:0] activate(input logic signed [nBits-1:0] a,
                                                         input logic [1:0] sel);
        case (sel)
            2'b00:   return a;
            2'b01:   return a[nBits-1] ? '0 : a;
            2'b10:   return a[nBits-1] ? '0 : ONE;
            default: return a[nBits-1] ? '1 : ((a == '0) ? '0 : ONE);
        endcase
    endfunction

    assign alu_s  = alu_result;
    assign accept = in_valid && in_ready;
    assign full   = (count == FULL_CNT);
    assign pop    = (count != '0) && out_ready;

`ifdef SAT_ACCUM_EN
    assign {ovf_p0, sum_p0} = sat_add(acc_p0, alu_s);
`else
    assign sum_p0 = acc_p0 + alu_s;
`endif

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        push      = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && in_last)
                    state_nxt = ACT;
            end
            ACT:  state_nxt = PUSH;
            PUSH: begin
                if (!full) begin
                    push      = 1'b1;
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= ACCUM;
        else
            state <= state_nxt;
    end

    // p0: accumulate accepted beats
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_p0     <= '0;
            first_p0   <= 1'b1;
            act_sel_p0 <= 2'b00;
        end else begin
            if (accept) begin
                acc_p0   <= first_p0 ? alu_s : sum_p0;
                first_p0 <= 1'b0;
                if (in_last)
                    act_sel_p0 <= act_sel;
            end
            if (push)
                first_p0 <= 1'b1;
        end
    end

    // p1: activation result, held until the FIFO has room
    always_ff @(posedge clk) begin
        if (reset)
            res_p1 <= '0;
        else if (state == ACT)
            res_p1 <= activate(acc_p0, act_sel_p0);
    end

`ifdef SAT_ACCUM_EN
    always_ff @(posedge clk) begin
        if (reset || push)
            sat_flag <= 1'b0;
        else if (accept && !first_p0 && ovf_p0)
            sat_flag <= 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= res_p1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign out_valid  = (count != '0);
    assign out_data   = out_valid ? mem[rd_ptr] : '0;
    assign fifo_count = count;

endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed, table-driven bench for neuron_accumulator (wrap build by default, SAT_ACCUM_EN aware).
module tb_neuron_accumulator;

    localparam int NB    = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          reset, in_valid, in_last, out_ready;
    logic [1:0]    act_sel;
    logic [NB-1:0] alu_result;
    logic          in_ready, out_valid;
    logic [NB-1:0] out_data;
    logic [AW:0]   fifo_count;
`ifdef SAT_ACCUM_EN
    logic          sat_flag;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          nb;
        logic [31:0] b0, b1, b2;
        logic [1:0]  act;
        logic [31:0] exp;
        logic        sat;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    neuron_accumulator #(.nBits(NB), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_result (alu_result),
        .in_last    (in_last),
        .act_sel    (act_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .fifo_count (fifo_count)
`ifdef SAT_ACCUM_EN
        ,
        .sat_flag   (sat_flag)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add_vec(input int nb, input logic [31:0] b0, input logic [31:0] b1,
                           input logic [31:0] b2, input logic [1:0] act,
                           input logic [31:0] exp, input logic sat);
        vec_t v;
        v.nb = nb; v.b0 = b0; v.b1 = b1; v.b2 = b2; v.act = act; v.exp = exp; v.sat = sat;
        vecs.push_back(v);
    endtask

    task automatic beat(input logic [31:0] v, input logic last, input logic [1:0] a);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1; alu_result = v; in_last = last; act_sel = a;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("beat_accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0; alu_result = '0; act_sel = 2'b00;
    endtask

    task automatic pop_one();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int          n;
        logic        sat_seen;
        logic [31:0] bv;

        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        act_sel = 2'b00; alu_result = '0;

        add_vec(3, 32'd5,  -32'sd3, 32'd10, 2'b00, 32'd12, 1'b0);
        add_vec(2, -32'sd7, 32'd2,  32'd0,  2'b01, 32'd0,  1'b0);
        add_vec(2, -32'sd7, 32'd9,  32'd0,  2'b10, 32'd1,  1'b0);
        add_vec(1, -32'sd4, 32'd0,  32'd0,  2'b11, 32'hFFFF_FFFF, 1'b0);
        add_vec(2, 32'd7,  -32'sd2, 32'd0,  2'b11, 32'd1,  1'b0);
        add_vec(2, 32'd3,  -32'sd3, 32'd0,  2'b11, 32'd0,  1'b0);
        add_vec(1, 32'd6,   32'd0,  32'd0,  2'b01, 32'd6,  1'b0);
        add_vec(1, -32'sd1, 32'd0,  32'd0,  2'b10, 32'd0,  1'b0);
        add_vec(1, 32'd0,   32'd0,  32'd0,  2'b10, 32'd1,  1'b0);
        add_vec(3, -32'sd5, 32'd20, -32'sd6, 2'b00, 32'd9, 1'b0);
`ifdef SAT_ACCUM_EN
        add_vec(2, 32'h7FFF_FFFF, 32'd1, 32'd0, 2'b00, 32'h7FFF_FFFF, 1'b1);
        add_vec(2, 32'h8000_0000, -32'sd1, 32'd0, 2'b00, 32'h8000_0000, 1'b1);
`else
        add_vec(2, 32'h7FFF_FFFF, 32'd1, 32'd0, 2'b00, 32'h8000_0000, 1'b0);
        add_vec(2, 32'h8000_0000, -32'sd1, 32'd0, 2'b00, 32'h7FFF_FFFF, 1'b0);
`endif

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready",  32'(in_ready),   32'd1);
        check("rst_out_valid", 32'(out_valid),  32'd0);
        check("rst_out_data",  out_data,        32'd0);
        check("rst_count",     32'(fifo_count), 32'd0);

        // Table: each neuron from an empty FIFO, latency and result checked
        foreach (vecs[i]) begin
            for (int j = 0; j < vecs[i].nb; j++) begin
                bv = (j == 0) ? vecs[i].b0 : ((j == 1) ? vecs[i].b1 : vecs[i].b2);
                beat(bv, (j == vecs[i].nb - 1), vecs[i].act);
            end
            n = 0;
            sat_seen = 1'b0;
            do begin
                @(negedge clk);
                n++;
`ifdef SAT_ACCUM_EN
                sat_seen = sat_seen | sat_flag;
`endif
            end while (!out_valid && n < 20);
            check($sformatf("vec%0d_latency", i), 32'(n), 32'd3);
            check($sformatf("vec%0d_data", i), out_data, vecs[i].exp);
            check($sformatf("vec%0d_count", i), 32'(fifo_count), 32'd1);
`ifdef SAT_ACCUM_EN
            check($sformatf("vec%0d_sat", i), 32'(sat_seen), 32'(vecs[i].sat));
`endif
            pop_one();
            @(negedge clk);
            check($sformatf("vec%0d_count_after_pop", i), 32'(fifo_count), 32'd0);
        end

        // Fill FIFO with out_ready low; fifth neuron stalls in PUSH
        for (int k = 1; k <= 5; k++) beat(32'(k), 1'b1, 2'b00);
        repeat (4) @(negedge clk);
        check("full_count",    32'(fifo_count), 32'd4);
        check("full_in_ready", 32'(in_ready),   32'd0);
        check("full_head",     out_data,        32'd1);
        pop_one();
        @(negedge clk);
        check("full_pop_no_same_cycle_push", 32'(fifo_count), 32'd3);
        check("full_pop_head", out_data, 32'd2);
        @(negedge clk);
        check("full_deferred_push", 32'(fifo_count), 32'd4);
        for (int k = 2; k <= 5; k++) begin
            check($sformatf("full_order_%0d", k), out_data, 32'(k));
            pop_one();
        end
        @(negedge clk);
        check("full_drained", 32'(fifo_count), 32'd0);

        // Simultaneous push and pop with two words queued
        beat(32'd21, 1'b1, 2'b00);
        beat(32'd22, 1'b1, 2'b00);
        beat(32'd23, 1'b1, 2'b00);
        @(negedge clk);
        @(negedge clk);
        check("pp_before_count", 32'(fifo_count), 32'd2);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("pp_after_count", 32'(fifo_count), 32'd2);
        check("pp_head_22", out_data, 32'd22);
        pop_one();
        check("pp_head_23", out_data, 32'd23);
        pop_one();
        @(negedge clk);
        check("pp_drained", 32'(out_valid), 32'd0);

        // Reset during ACT with two words queued, then during a partial neuron
        beat(32'd31, 1'b1, 2'b00);
        beat(32'd32, 1'b1, 2'b00);
        beat(32'd33, 1'b1, 2'b00);
        @(negedge clk);
        check("ract_count_before", 32'(fifo_count), 32'd2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("ract_count",     32'(fifo_count), 32'd0);
        check("ract_out_valid", 32'(out_valid),  32'd0);
        check("ract_in_ready",  32'(in_ready),   32'd1);
        check("ract_out_data",  out_data,        32'd0);
        beat(32'd100, 1'b0, 2'b00);
        pulse_reset();
        beat(32'd3, 1'b1, 2'b00);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        check("rpart_latency", 32'(n), 32'd3);
        check("rpart_data", out_data, 32'd3);
        pop_one();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/neuron_accumulator.md
Name: neuron_accumulator

Overview:
- Downstream of the second-stage ALU result (add/mul/set-if-GE/pass).
- Accumulates a stream of signed ALU results belonging to one neuron and applies a selectable activation on the last beat.
- Queues finished neuron outputs in a small FIFO for register-file writeback.
- Decouples the ALU datapath from writeback through valid/ready handshakes on both sides.

Parameters:
- nBits, 32, data width of ALU results, accumulator and output words.
- DEPTH, 4, output FIFO depth in words; power of 2, minimum 2.
- AW, 2, log2(DEPTH); width of FIFO pointers.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  alu_result beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- alu_result  input  nBits  signed ALU result to accumulate.
- in_last  input  1  final beat of the current neuron.
- act_sel  input  2  activation select; sampled only on the accepted last beat.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  writeback consumes out_data this cycle.
- out_data  output  nBits  FIFO head (first-word fall-through).
- fifo_count  output  AW+1  words held in FIFO, 0..DEPTH.

Behaviour:
- States: ACCUM, ACT, PUSH. Reset state is ACCUM.
- Reset values: in_ready=1, out_valid=0, out_data=0, fifo_count=0; acc=0; first=1; FIFO pointers=0.
- in_ready=1 only in ACCUM. A beat is accepted when in_valid && in_ready.
- Accumulation on an accepted beat:
  - first=1: acc<=alu_result and first<=0.
  - first=0: acc<=acc+alu_result, signed, nBits wide.
- Accepted beat with in_last=1: latch act_sel and go to ACT. A single-beat neuron (first=1 and in_last=1) is legal.
- ACT (1 cycle): compute res from the final acc per latched act_sel, then go to PUSH.
  - 00: pass, res=acc.
  - 01: ReLU, res = (acc<0) ? 0 : acc.
  - 10: step, res = (acc>=0) ? 1 : 0.
  - 11: sign, res = -1 / 0 / +1 for acc <0 / ==0 / >0.
- PUSH:
  - FIFO not full at start of cycle: write res, go to ACCUM with first<=1.
  - FIFO full: stay in PUSH, holding res; in_ready stays 0.
- Latency: last beat accepted at cycle t → ACT at t+1 → FIFO write at t+2 → out_valid/out_data visible at t+3 if the FIFO was empty.
- FIFO:
  - out_valid = (fifo_count != 0); out_data = mem[rd_ptr], registered storage.
  - Pop when out_valid && out_ready. Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle with count in 1..DEPTH-1: count unchanged, both pointers advance.
  - Full (count==DEPTH): no push. A pop in that cycle does not enable a same-cycle push; the push happens the next cycle.
  - Empty: out_ready ignored, count never underflows.
- Wrap-around: without SAT_ACCUM_EN, acc overflow wraps two's-complement.
- Reset in any state: partial acc and pending res are discarded, FIFO is flushed, and reset values apply on the next edge.
- alu_result and in_last are ignored when not accepted. act_sel is ignored except on the accepted last beat.

Optional Feature:
- Macro SAT_ACCUM_EN.
- Defined:
  - Accumulation saturates to +2^(nBits-1)-1 / -2^(nBits-1) on signed overflow.
  - Adds output port sat_flag (1 bit), a sticky flag set on any saturation.
  - sat_flag clears on reset and when that neuron's result is pushed to the FIFO.
  - Activation applies to the saturated value.
- Undefined: wrap-around arithmetic; no sat_flag port.

Test Plan:
- Beats 5, -3, 10 (last, act_sel=00), out_ready=1 → out_valid at t+3, out_data=12, fifo_count=1 then 0 after pop.
- Beats -7, 2 (last, act_sel=01) → out_data=0. Beats -7, 9 (last, act_sel=10) → out_data=1. Single beat -4 (last, act_sel=11) → out_data=0xFFFFFFFF.
- out_ready=0, push 5 single-beat neurons (values 1..5, act 00) → fifo_count=4, state held in PUSH, in_ready=0. Then out_ready=1 → pops 1,2,3,4,5 in order.
- Steady stream with out_ready=1 and count in 1..3 → simultaneous push/pop keeps count constant; output order is preserved.
- Beats 0x7FFFFFFF, 1 (last, act 00) → wrap build gives out_data=0x80000000. SAT_ACCUM_EN build gives 0x7FFFFFFF with sat_flag=1.
- Assert reset during ACT with 2 words queued → next cycle fifo_count=0, out_valid=0, in_ready=1; next neuron 3 (last) → out_data=3.
